// File: rtl/mux8_mem_arbiter.sv
// Arbitrates eight requesters onto one memory port: picks a winner, drives the
// mux8 select, holds the memory strobe until mem_resp, then pulses req_resp.
module mux8_mem_arbiter #(
  parameter bit RR_ENABLE = 1'b1,
  parameter int N_REQ     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req_read,
  input  logic [7:0] req_write,
  output logic [7:0] req_resp,
  output logic [2:0] sel,
  output logic       mem_read,
  output logic       mem_write,
  input  logic       mem_resp,
  output logic       busy
);

  if (N_REQ != 8) begin : g_bad_n_req
    $error("mux8_mem_arbiter: N_REQ must be 8 to match the 3-bit mux select");
  end

  // Handshake: a requester raises req_read/req_write and holds it until its
  // req_resp bit pulses for one cycle; it may still be high during that pulse.
  // The memory sees a level strobe held until the one-cycle mem_resp.
  typedef enum logic [0:0] {IDLE, BUSY} state_t;

  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] last_q, last_d;
  logic       mem_read_q, mem_read_d;
  logic       mem_write_q, mem_write_d;
  logic       busy_q, busy_d;
  logic [7:0] resp_q, resp_d;

  logic [7:0] pending;
  logic [2:0] scan_idx;
  logic [2:0] winner;
  logic       found;
  logic       holdoff;

  assign pending = req_read | req_write;

  always_comb begin
    found    = 1'b0;
    winner   = 3'd0;
    scan_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      scan_idx = RR_ENABLE ? 3'(last_q + 3'(i + 1)) : 3'(i);
      if (!found && pending[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  // In the req_resp cycle the served requester's lines are stale; if it would
  // win again, wait one cycle rather than granting anyone else in its place.
  assign holdoff = (resp_q != 8'h00) && (winner == last_q);

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    last_d      = last_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    busy_d      = busy_q;
    resp_d      = 8'h00;
    case (state_q)
      IDLE: begin
        if (found && !holdoff) begin
          sel_d       = winner;
          mem_write_d = req_write[winner];
          mem_read_d  = !req_write[winner];
          busy_d      = 1'b1;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (mem_resp) begin
          resp_d      = 8'h01 << sel_q;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          busy_d      = 1'b0;
          last_d      = sel_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= 3'd0;
      last_q      <= 3'd7;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      busy_q      <= 1'b0;
      resp_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      busy_q      <= busy_d;
      resp_q      <= resp_d;
    end
  end

  assign sel       = sel_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign busy      = busy_q;
  assign req_resp  = resp_q;

endmodule
